// File: rtl/uart_cmd_wrapper_if.sv
// Byte-level handshake between the UART/interpreter environment and the
// command wrapper: rx byte hand-off, assembled frame, and response transmit.
interface uart_cmd_wrapper_if;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        resp_sent;
    logic        frm_err;

    // master = UART + command interpreter side, slave = the wrapper
    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
        input  clr_rx_rdy, cmd, data, cmd_rdy, tx_data, trmt, resp_sent, frm_err
    );
    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
        output clr_rx_rdy, cmd, data, cmd_rdy, tx_data, trmt, resp_sent, frm_err
    );
endinterface

// File: rtl/uart_cmd_wrapper.sv
// Assembles 3-byte command frames (cmd, data hi, data lo) from a UART receiver
// with an inter-byte timeout, and sends single response bytes to the transmitter.
module uart_cmd_wrapper #(
    parameter int TO_WIDTH = 9
) (
    input  logic               clk,
    input  logic               rst,
    uart_cmd_wrapper_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, GET_HI, GET_LO} rx_state_e;
    typedef enum logic       {TX_IDLE, TX_BUSY}     tx_state_e;

    rx_state_e           rx_state_q, rx_state_d;
    logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [15:0]         data_q, data_d;
    logic                cmd_rdy_q, cmd_rdy_d;
    logic                accept;
    logic                frm_err;

    tx_state_e           tx_state_q, tx_state_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                trmt_q, trmt_d;
    logic                resp_sent;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= IDLE;
            to_cnt_q   <= '0;
            cmd_q      <= 8'h00;
            data_q     <= 16'h0000;
            cmd_rdy_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_data_q  <= 8'h00;
            trmt_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            to_cnt_q   <= to_cnt_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            cmd_rdy_q  <= cmd_rdy_d;
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            trmt_q     <= trmt_d;
        end
    end

    // A held frame blocks intake, so a byte arriving on the release cycle
    // stays pending in the UART and is taken on the next cycle.
    always_comb begin
        rx_state_d = rx_state_q;
        to_cnt_d   = to_cnt_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        cmd_rdy_d  = cmd_rdy_q;
        frm_err    = 1'b0;
        accept     = bus.rx_rdy & ~cmd_rdy_q;

        if (cmd_rdy_q && bus.clr_cmd_rdy)
            cmd_rdy_d = 1'b0;

        case (rx_state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (accept) begin
                    cmd_d      = bus.rx_data;
                    rx_state_d = GET_HI;
                end
            end
            GET_HI: begin
                if (accept) begin
                    data_d[15:8] = bus.rx_data;
                    to_cnt_d     = '0;
                    rx_state_d   = GET_LO;
                end else if (&to_cnt_q) begin
                    to_cnt_d   = '0;
                    frm_err    = 1'b1;
                    rx_state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                end
            end
            GET_LO: begin
                if (accept) begin
                    data_d[7:0] = bus.rx_data;
                    to_cnt_d    = '0;
                    cmd_rdy_d   = 1'b1;
                    rx_state_d  = IDLE;
                end else if (&to_cnt_q) begin
                    to_cnt_d   = '0;
                    frm_err    = 1'b1;
                    rx_state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                end
            end
            default: begin
                to_cnt_d   = '0;
                rx_state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        trmt_d     = 1'b0;
        resp_sent  = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                if (bus.send_resp) begin
                    tx_data_d  = bus.resp;
                    trmt_d     = 1'b1;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (bus.tx_done) begin
                    resp_sent  = 1'b1;
                    tx_state_d = TX_IDLE;
                end
            end
        endcase
    end

    // Combinational pulses are masked while reset is applied so an aborted
    // frame or response never reports an error or completion.
    assign bus.clr_rx_rdy = accept & ~rst;
    assign bus.frm_err    = frm_err & ~rst;
    assign bus.resp_sent  = resp_sent & ~rst;
    assign bus.cmd        = cmd_q;
    assign bus.data       = data_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.trmt       = trmt_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench for uart_cmd_wrapper: stimulus pushes expected frame/error
// and transmit events; a negedge monitor pops and compares as the DUT emits them.
module tb_uart_cmd_wrapper;

    localparam logic [1:0] EV_FRAME = 2'd0, EV_FERR = 2'd1, EV_TRMT = 2'd2, EV_RSENT = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [23:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_cmd_wrapper_if u_if ();

    uart_cmd_wrapper #(.TO_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    ev_t  rx_q[$];
    ev_t  tx_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   clr_cnt     = 0;
    int   ferr_cyc    = 0;
    logic cmd_rdy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_ev(input bit is_tx, input ev_t got);
        ev_t exp;
        vectors++;
        if (is_tx ? (tx_q.size() == 0) : (rx_q.size() == 0)) begin
            miscompares++;
            $display("FAIL %s_event unexpected: got kind=%0d val=%h, none expected",
                     is_tx ? "tx" : "rx", got.kind, got.val);
        end else begin
            if (is_tx) exp = tx_q.pop_front();
            else       exp = rx_q.pop_front();
            if (got !== exp) begin
                miscompares++;
                $display("FAIL %s_event got kind=%0d val=%h expected kind=%0d val=%h",
                         is_tx ? "tx" : "rx", got.kind, got.val, exp.kind, exp.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (u_if.clr_rx_rdy === 1'b1) clr_cnt++;
        if (u_if.cmd_rdy === 1'b1 && cmd_rdy_prev !== 1'b1)
            check_ev(1'b0, {EV_FRAME, u_if.cmd, u_if.data});
        if (u_if.frm_err === 1'b1) begin
            ferr_cyc = cyc;
            check_ev(1'b0, {EV_FERR, 24'h0});
        end
        if (u_if.trmt === 1'b1)
            check_ev(1'b1, {EV_TRMT, 16'h0, u_if.tx_data});
        if (u_if.resp_sent === 1'b1)
            check_ev(1'b1, {EV_RSENT, 16'h0, u_if.tx_data});
        cmd_rdy_prev = u_if.cmd_rdy;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        bit ok = 1'b0;
        @(posedge clk); #1;
        u_if.rx_rdy  = 1'b1;
        u_if.rx_data = b;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (u_if.clr_rx_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL put_byte timeout: byte %h never consumed, required within 64 cycles", b);
        end
        @(posedge clk); #1;
        u_if.rx_rdy = 1'b0;
    endtask

    task automatic release_cmd();
        @(posedge clk); #1 u_if.clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 u_if.clr_cmd_rdy = 1'b0;
    endtask

    task automatic send(input logic [7:0] r);
        @(posedge clk); #1;
        u_if.resp      = r;
        u_if.send_resp = 1'b1;
        @(posedge clk); #1 u_if.send_resp = 1'b0;
    endtask

    task automatic done_pulse();
        @(posedge clk); #1 u_if.tx_done = 1'b1;
        @(posedge clk); #1 u_if.tx_done = 1'b0;
    endtask

    function automatic ev_t frame(input logic [7:0] c, input logic [15:0] d);
        return {EV_FRAME, c, d};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int t0;
        rst              = 1'b1;
        u_if.rx_rdy      = 1'b0;
        u_if.rx_data     = 8'h00;
        u_if.clr_cmd_rdy = 1'b0;
        u_if.resp        = 8'h00;
        u_if.send_resp   = 1'b0;
        u_if.tx_done     = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", {27'h0, u_if.clr_rx_rdy, u_if.cmd_rdy, u_if.trmt, u_if.resp_sent, u_if.frm_err}, 32'h0);
        chk("reset_cmd_data", {8'h0, u_if.cmd, u_if.data}, 32'h0);
        chk("reset_tx_data", {24'h0, u_if.tx_data}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // spaced bytes 02,12,34
        rx_q.push_back(frame(8'h02, 16'h1234));
        c0 = clr_cnt;
        put_byte(8'h02); repeat (4) @(posedge clk);
        put_byte(8'h12); repeat (4) @(posedge clk);
        put_byte(8'h34);
        repeat (10) @(negedge clk);
        chk("clr_rx_rdy_pulses", clr_cnt - c0, 32'd3);
        chk("cmd_rdy_held", {31'h0, u_if.cmd_rdy}, 32'd1);
        release_cmd();
        #1 chk("cmd_rdy_released", {31'h0, u_if.cmd_rdy}, 32'd0);

        // byte while frame held, then late acceptance
        rx_q.push_back(frame(8'h05, 16'h0080));
        put_byte(8'h05); put_byte(8'h00); put_byte(8'h80);
        u_if.rx_rdy  = 1'b1;
        u_if.rx_data = 8'h01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("blocked_clr_rx_rdy", {31'h0, u_if.clr_rx_rdy}, 32'd0);
        end
        chk("held_cmd_data", {8'h0, u_if.cmd, u_if.data}, 32'h00050080);
        @(posedge clk); #1 u_if.clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 u_if.clr_cmd_rdy = 1'b0;
        #1;
        chk("cmd_rdy_cleared", {31'h0, u_if.cmd_rdy}, 32'd0);
        chk("late_accept", {31'h0, u_if.clr_rx_rdy}, 32'd1);
        @(posedge clk); #1 u_if.rx_rdy = 1'b0;
        rx_q.push_back(frame(8'h01, 16'h0203));
        put_byte(8'h02); put_byte(8'h03);
        repeat (2) @(posedge clk);
        release_cmd();

        // timeout after byte 03, then clean frame
        rx_q.push_back('{kind: EV_FERR, val: 24'h0});
        put_byte(8'h03);
        t0 = cyc;
        repeat (20) @(posedge clk);
        #1 chk("ferr_delay", ferr_cyc - t0, 32'd15);
        rx_q.push_back(frame(8'h04, 16'hFFFE));
        put_byte(8'h04); put_byte(8'hFF); put_byte(8'hFE);
        repeat (2) @(posedge clk);
        release_cmd();

        // byte 1 lands in the saturation cycle
        rx_q.push_back(frame(8'h07, 16'h0809));
        put_byte(8'h07);
        t0 = cyc;
        repeat (14) @(posedge clk);
        put_byte(8'h08);
        chk("sat_accept_cycle", cyc - t0, 32'd16);
        put_byte(8'h09);
        repeat (2) @(posedge clk);
        release_cmd();

        // transmit: busy ignores second request, tx_done in idle ignored
        tx_q.push_back('{kind: EV_TRMT,  val: 24'h0000A5});
        tx_q.push_back('{kind: EV_RSENT, val: 24'h0000A5});
        send(8'hA5);
        send(8'h00);
        chk("tx_hold_busy", {24'h0, u_if.tx_data}, 32'h000000A5);
        repeat (2) @(posedge clk);
        done_pulse();
        #1 chk("tx_data_after_done", {24'h0, u_if.tx_data}, 32'h000000A5);
        done_pulse();

        // simultaneous rx frame and response
        rx_q.push_back(frame(8'h0B, 16'hC0DE));
        tx_q.push_back('{kind: EV_TRMT,  val: 24'h00005A});
        tx_q.push_back('{kind: EV_RSENT, val: 24'h00005A});
        fork
            begin put_byte(8'h0B); put_byte(8'hC0); put_byte(8'hDE); end
            begin send(8'h5A); repeat (3) @(posedge clk); done_pulse(); end
        join
        repeat (2) @(posedge clk);
        release_cmd();

        // reset mid-frame and mid-transmit
        tx_q.push_back('{kind: EV_TRMT, val: 24'h00003C});
        send(8'h3C);
        put_byte(8'h09); put_byte(8'h11);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("rst_tx_data", {24'h0, u_if.tx_data}, 32'h0);
        chk("rst_cmd_data", {8'h0, u_if.cmd, u_if.data}, 32'h0);
        done_pulse();
        rx_q.push_back(frame(8'h06, 16'h0000));
        put_byte(8'h06); put_byte(8'h00); put_byte(8'h00);
        repeat (5) @(posedge clk);
        release_cmd();

        repeat (5) @(posedge clk);
        chk("rx_queue_drained", rx_q.size(), 32'd0);
        chk("tx_queue_drained", tx_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_cmd_wrapper.md
UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

Interface
REQ-001 SHALL have parameter TO_WIDTH, default 9: width of the inter-byte timeout counter; set to 22 for the real quad.
REQ-002 SHALL have port clk, input, 1: single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port rx_rdy, input, 1: UART receiver holds a received byte.
REQ-005 SHALL have port rx_data, input, 8: received byte, valid while rx_rdy=1.
REQ-006 SHALL have port clr_rx_rdy, output, 1: one-cycle pulse, byte consumed.
REQ-007 SHALL have port cmd, output, 8: opcode of the assembled frame.
REQ-008 SHALL have port data, output, 16: payload of the assembled frame.
REQ-009 SHALL have port cmd_rdy, output, 1: complete frame available on cmd/data.
REQ-010 SHALL have port clr_cmd_rdy, input, 1: consumer releases the frame.
REQ-011 SHALL have port resp, input, 8: response byte from the command interpreter.
REQ-012 SHALL have port send_resp, input, 1: request to transmit resp.
REQ-013 SHALL have port tx_data, output, 8: byte presented to the UART transmitter.
REQ-014 SHALL have port trmt, output, 1: one-cycle transmit start pulse.
REQ-015 SHALL have port tx_done, input, 1: one-cycle pulse, transmitter finished its byte.
REQ-016 SHALL have port resp_sent, output, 1: one-cycle pulse, response fully transmitted.
REQ-017 SHALL have port frm_err, output, 1: one-cycle pulse, partial frame discarded on timeout.

Function
REQ-018 SHALL transmit each frame as 3 bytes in order: cmd, data[15:8], data[7:0].
REQ-019 Receive FSM SHALL have states IDLE (wait for byte 0), GET_HI (wait for byte 1), GET_LO (wait for byte 2).
REQ-020 Any state with rx_rdy=1 and cmd_rdy=0: capture rx_data into the corresponding field, assert clr_rx_rdy combinationally in the same cycle, and advance IDLE->GET_HI->GET_LO->IDLE.
REQ-021 On acceptance of byte 2: set cmd_rdy=1 on the next edge, with cmd/data already holding all three bytes.
REQ-022 While cmd_rdy=1: SHALL NOT accept rx bytes (clr_rx_rdy=0, rx_rdy ignored); cmd and data SHALL hold stable.
REQ-023 clr_cmd_rdy=1 SHALL clear cmd_rdy on the next edge; clr_cmd_rdy with cmd_rdy=0 has no effect.
REQ-024 A byte arriving in the same cycle cmd_rdy is cleared SHALL be accepted one cycle later, not lost.
REQ-025 Timeout counter SHALL clear on every accepted byte and in IDLE, and SHALL increment each cycle in GET_HI/GET_LO.
REQ-026 Counter reaching all-ones in GET_HI/GET_LO with rx_rdy=0: return to IDLE, pulse frm_err for 1 cycle, leave cmd_rdy=0; cmd/data values are don't-care.
REQ-027 rx_rdy=1 in the same cycle the counter saturates: the byte SHALL be accepted and no frm_err asserted.
REQ-028 Transmit side SHALL be a 2-state FSM: TX_IDLE, TX_BUSY.
REQ-029 send_resp in TX_IDLE: latch resp into tx_data, pulse trmt the next cycle, enter TX_BUSY.
REQ-030 In TX_BUSY, send_resp SHALL be ignored; tx_data SHALL hold stable.
REQ-031 tx_done in TX_BUSY: pulse resp_sent in the same cycle and return to TX_IDLE; tx_done in TX_IDLE is ignored.
REQ-032 Receive and transmit FSMs SHALL operate independently; simultaneous rx acceptance and send_resp both proceed.

Reset
REQ-033 rst=1 at a clock edge SHALL force: both FSMs to IDLE/TX_IDLE, counter=0, cmd=8'h00, data=16'h0000, tx_data=8'h00, and cmd_rdy, clr_rx_rdy, trmt, resp_sent, frm_err all =0.
REQ-034 rst mid-frame or mid-transmit SHALL discard the partial frame or response with no frm_err or resp_sent pulse; the first byte after reset is treated as byte 0.

Verification
REQ-035 Bytes 02,12,34 presented with gaps of 5 cycles -> 3 clr_rx_rdy pulses; cmd_rdy=1 with cmd=02, data=1234; stays set until clr_cmd_rdy.
REQ-036 Frame 05,00,80 complete, then byte 01 presented while cmd_rdy=1 -> clr_rx_rdy=0 and cmd/data unchanged; pulse clr_cmd_rdy -> byte 01 accepted in the following cycle.
REQ-037 TO_WIDTH=4, byte 03 then silence -> frm_err pulse 15 cycles after GET_HI entry; next bytes 04,FF,FE -> cmd=04, data=FFFE.
REQ-038 TO_WIDTH=4, byte 1 arrives in the exact saturation cycle -> accepted, no frm_err.
REQ-039 send_resp with resp=A5 -> trmt pulse, tx_data=A5; second send_resp with resp=00 while busy is ignored; tx_done -> resp_sent pulse, tx_data still A5.
REQ-040 rst asserted after byte 1 of a frame, then bytes 06,00,00 -> cmd=06, data=0000, no frm_err.
